vx_gbar_unit: RTL and testbench

VX_GBAR_UNIT -- requirements
Module: VX_gbar_unit

---
 rtl/vx_gbar_unit.sv | 142 ++++++++++++++
 tb/tb_vx_gbar_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_gbar_unit.sv
// Global barrier unit: round-robin accepts per-core barrier arrivals and broadcasts a one-cycle release.
// Optional performance counters are built only when GBAR_PERF_EN is defined.
module vx_gbar_unit #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 4,
    localparam int NC_WIDTH    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int NB_WIDTH    = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CORES-1:0]                req_valid,
    input  logic [NUM_CORES-1:0][NB_WIDTH-1:0]  req_id,
    input  logic [NUM_CORES-1:0][NC_WIDTH-1:0]  req_size_m1,
    output logic [NUM_CORES-1:0]                req_ready,
    output logic                                rsp_valid,
    output logic [NB_WIDTH-1:0]                 rsp_id,
    output logic [31:0]                         perf_stalls,
    output logic [31:0]                         perf_releases
);

    // Handshake: a core's arrival is accepted in the cycle req_valid[i] && req_ready[i];
    // a waiting core keeps valid/id/size stable until then, and rsp_valid is a one-cycle broadcast.

    logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] arrive_q, arrive_d;
    logic [NC_WIDTH-1:0]                    ptr_q, ptr_d;
    logic                                   rsp_valid_q, rsp_valid_d;
    logic [NB_WIDTH-1:0]                    rsp_id_q, rsp_id_d;

    logic                  gnt_found;
    logic [NC_WIDTH-1:0]   gnt_idx;
    logic                  accept;
    logic [NB_WIDTH-1:0]   acc_id;
    logic [NC_WIDTH-1:0]   acc_size;
    logic                  id_ok;
    logic [NUM_CORES-1:0]  next_mask;
    logic [NC_WIDTH:0]     arrive_cnt;
    logic [NC_WIDTH:0]     target_cnt;
    logic                  complete;
    int                    cand;

    // Search starts at the priority pointer and wraps once around all cores.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[NC_WIDTH-1:0];
            end
        end
    end

    assign accept    = gnt_found && reset;
    assign req_ready = accept ? (NUM_CORES'(1) << gnt_idx) : '0;

    always_comb begin
        acc_id     = req_id[gnt_idx];
        acc_size   = req_size_m1[gnt_idx];
        id_ok      = (int'(acc_id) < NUM_BARRIERS);
        next_mask  = '0;
        if (id_ok) begin
            next_mask = arrive_q[acc_id] | (NUM_CORES'(1) << gnt_idx);
        end
        arrive_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            arrive_cnt = arrive_cnt + (NC_WIDTH+1)'(next_mask[i]);
        end
        target_cnt = (NC_WIDTH+1)'(acc_size) + 1'b1;
        complete   = accept && id_ok && (arrive_cnt == target_cnt);
    end

    // Out-of-range IDs are still granted so the requester drains, but touch no mask.
    always_comb begin
        arrive_d    = arrive_q;
        ptr_d       = ptr_q;
        rsp_valid_d = complete;
        rsp_id_d    = rsp_id_q;
        if (accept) begin
            if (int'(gnt_idx) == NUM_CORES - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
            if (id_ok) begin
                arrive_d[acc_id] = complete ? '0 : next_mask;
            end
        end
        if (complete) begin
            rsp_id_d = acc_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arrive_q    <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            arrive_q    <= arrive_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

`ifdef GBAR_PERF_EN
    logic [31:0] stalls_q, stalls_d;
    logic [31:0] releases_q, releases_d;

    // Releases are counted on the accepting edge so the count moves with rsp_valid.
    always_comb begin
        stalls_d   = stalls_q + 32'(|(req_valid & ~req_ready));
        releases_d = releases_q + 32'(complete);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stalls_q   <= '0;
            releases_q <= '0;
        end else begin
            stalls_q   <= stalls_d;
            releases_q <= releases_d;
        end
    end

    assign perf_stalls   = stalls_q;
    assign perf_releases = releases_q;
`else
    assign perf_stalls   = '0;
    assign perf_releases = '0;
`endif

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Bench for vx_gbar_unit: directed barrier scenarios plus random traffic, checked
// against a queue/array reference model and an expected-release scoreboard.
module tb_vx_gbar_unit;

    localparam int NC  = 4;
    localparam int NB  = 4;
    localparam int NCW = 2;
    localparam int NBW = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NC-1:0]            req_valid;
    logic [NC-1:0][NBW-1:0]   req_id;
    logic [NC-1:0][NCW-1:0]   req_size_m1;
    logic [NC-1:0]            req_ready;
    logic                     rsp_valid;
    logic [NBW-1:0]           rsp_id;
    logic [31:0]              perf_stalls;
    logic [31:0]              perf_releases;

    // clock / reset
    always #5 clk = ~clk;

    vx_gbar_unit #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_id        (req_id),
        .req_size_m1   (req_size_m1),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .perf_stalls   (perf_stalls),
        .perf_releases (perf_releases)
    );

    int checks = 0;
    int errors = 0;
    logic [NBW-1:0] exp_q[$];

    bit pend_v[NC];
    int pend_id[NC];
    int pend_sz[NC];
    bit acc_s[NC];

    int m_mask[NB];
    int m_ptr;
    int m_stalls;
    int m_releases;

    // driver tasks
    task automatic apply();
        for (int i = 0; i < NC; i++) begin
            req_valid[i]   = pend_v[i];
            req_id[i]      = NBW'(pend_id[i]);
            req_size_m1[i] = NCW'(pend_sz[i]);
        end
    endtask

    task automatic post(input int c, input int id, input int sz);
        pend_v[c]  = 1'b1;
        pend_id[c] = id;
        pend_sz[c] = sz;
        apply();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit any_pend();
        bit r;
        r = 1'b0;
        for (int i = 0; i < NC; i++) r = r | pend_v[i];
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((any_pend() || exp_q.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout: pending=%0d queued=%0d after %0d cycles, required idle", any_pend(), exp_q.size(), n);
            for (int i = 0; i < NC; i++) pend_v[i] = 1'b0;
            apply();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < NC; i++) pend_v[i] = 1'b0;
        apply();
        step(3);
        reset = 1'b1;
    endtask

    function automatic int exp_stalls();
`ifdef GBAR_PERF_EN
        return m_stalls;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_releases();
`ifdef GBAR_PERF_EN
        return m_releases;
`else
        return 0;
`endif
    endfunction

    task automatic check_perf(input string tag);
        checks += 2;
        if (perf_stalls !== 32'(exp_stalls())) begin
            errors++;
            $display("FAIL %s_stalls: got %0d, required %0d", tag, perf_stalls, exp_stalls());
        end
        if (perf_releases !== 32'(exp_releases())) begin
            errors++;
            $display("FAIL %s_releases: got %0d, required %0d", tag, perf_releases, exp_releases());
        end
    endtask

    // Pending requests drop once their handshake completes; everything else is held.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NC; i++) if (acc_s[i]) pend_v[i] = 1'b0;
        apply();
    end

    // Reference model: evaluated with the inputs settled, ahead of the accepting edge.
    always @(negedge clk) begin
        int g;
        int c;
        int id;
        int sz;
        int mask;
        logic [NC-1:0] exp_rdy;
        for (int i = 0; i < NC; i++) acc_s[i] = req_valid[i] && req_ready[i];
        if (!reset) begin
            for (int b = 0; b < NB; b++) m_mask[b] = 0;
            m_ptr      = 0;
            m_stalls   = 0;
            m_releases = 0;
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL ready_in_reset: got %b, required 0000", req_ready);
            end
        end else begin
            g = -1;
            for (int k = 0; k < NC; k++) begin
                c = (m_ptr + k) % NC;
                if (g < 0 && req_valid[c]) g = c;
            end
            exp_rdy = (g >= 0) ? (NC'(1) << g) : '0;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL grant: got %b, required %b (valid %b)", req_ready, exp_rdy, req_valid);
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % NC;
                id    = int'(req_id[g]);
                sz    = int'(req_size_m1[g]);
                mask  = m_mask[id] | (1 << g);
                if ($countones(mask) == sz + 1) begin
                    m_mask[id] = 0;
                    exp_q.push_back(NBW'(id));
                    m_releases++;
                end else begin
                    m_mask[id] = mask;
                end
                if ((req_valid & ~exp_rdy) != '0) m_stalls++;
            end
        end
    end

    // Monitor: every release must land exactly one edge after its completing accept.
    always @(posedge clk) begin
        logic [NBW-1:0] e;
        #3;
        if (!reset) begin
            exp_q.delete();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rsp_in_reset: got %b, required 0", rsp_valid);
            end
        end else if (rsp_valid === 1'b1 || exp_q.size() != 0) begin
            checks++;
            if (rsp_valid !== 1'b1) begin
                errors++;
                e = exp_q.pop_front();
                $display("FAIL rsp_missing: got rsp_valid=%b, required 1 with id %0d", rsp_valid, e);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d, required no release", rsp_id);
            end else begin
                e = exp_q.pop_front();
                if (rsp_id !== e) begin
                    errors++;
                    $display("FAIL rsp_id: got %0d, required %0d", rsp_id, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < NC; i++) begin
            pend_v[i]  = 1'b0;
            pend_id[i] = 0;
            pend_sz[i] = 0;
        end
        apply();
        step(2);
        checks++;
        if (rsp_id !== '0) begin
            errors++;
            $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id);
        end
        check_perf("reset");
        reset = 1'b1;
        step(1);

        // four staggered arrivals on id 2, then a fresh epoch proves the mask cleared
        for (int c = 0; c < NC; c++) begin
            post(c, 2, 3);
            step(1);
        end
        wait_idle();
        post(0, 2, 1);
        step(1);
        post(1, 2, 1);
        wait_idle();

        // all four at once: round-robin drains them over four cycles
        do_reset();
        step(1);
        for (int c = 0; c < NC; c++) post(c, 0, 3);
        wait_idle();
        check_perf("all_four");

        // repeated arrival by one core must not complete a two-core barrier
        post(1, 1, 1);
        wait_idle();
        post(1, 1, 1);
        wait_idle();
        post(3, 1, 1);
        wait_idle();

        // interleaved barriers release on consecutive cycles
        post(0, 0, 1);
        step(1);
        post(0, 1, 1);
        step(1);
        post(2, 0, 1);
        step(1);
        post(2, 1, 1);
        wait_idle();

        // re-arrival while the release pulse is high joins the next epoch
        post(0, 3, 1);
        step(1);
        post(1, 3, 1);
        step(1);
        post(2, 3, 1);
        step(1);
        post(3, 3, 1);
        wait_idle();

        // reset after three of four arrivals discards them
        for (int c = 0; c < 3; c++) begin
            post(c, 3, 3);
            step(1);
        end
        do_reset();
        step(1);
        check_perf("after_reset");
        for (int c = 0; c < NC; c++) begin
            post(c, 3, 3);
            step(1);
        end
        wait_idle();

        // random traffic
        repeat (1500) begin
            for (int c = 0; c < NC; c++) begin
                if (!pend_v[c] && $urandom_range(0, 2) == 0)
                    post(c, int'($urandom_range(0, NB-1)), int'($urandom_range(0, NC-1)));
            end
            step(1);
        end
        wait_idle();
        check_perf("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
